// File: rtl/kamus_csr_file.sv
// kamus_csr_file: CSR storage and read-modify-write, 64-bit cycle/instret counters,
// timer compare, and trap/MRET state for the kamus core.
// Build option: define KAMUS_MACHINE_MODE_EN for the full machine-mode map; without it
// only the user counters exist and trap/MRET inputs are ignored.
module kamus_csr_file #(
  parameter logic [31:0] HART_ID     = 32'h0,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0100
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        csr_req_i,
  input  logic [1:0]  csr_op_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_wdata_i,
  output logic [31:0] csr_rdata_o,
  output logic        csr_illegal_o,
  input  logic        instr_retire_i,
  input  logic        trap_i,
  input  logic [31:0] trap_cause_i,
  input  logic [31:0] trap_pc_i,
  input  logic [31:0] trap_tval_i,
  input  logic        mret_i,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic        mie_global_o,
  output logic        timer_irq_o
);

  logic [63:0] r_cycle;
  logic [63:0] r_instret;
  logic [31:0] w_rdata;
  logic        w_known;
  logic        w_wr_intent;
  logic        w_ro;

`ifdef KAMUS_MACHINE_MODE_EN
  logic [63:0] r_timecmp;
  logic        r_mie;
  logic        r_mpie;
  logic        r_mtie;
  logic        r_mtip;
  logic [31:2] r_mtvec;
  logic [31:0] r_mscratch;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic [31:0] r_mbadaddr;
  logic [31:0] w_wval;
  logic        w_we;
`endif

  // Read decode: old value of the addressed CSR, unknown addresses flagged.
  always_comb begin
    w_rdata = '0;
    w_known = 1'b1;
    case (csr_addr_i)
      12'hC00, 12'hC01: w_rdata = r_cycle[31:0];
      12'hC02:          w_rdata = r_instret[31:0];
      12'hC80, 12'hC81: w_rdata = r_cycle[63:32];
      12'hC82:          w_rdata = r_instret[63:32];
`ifdef KAMUS_MACHINE_MODE_EN
      12'hF11, 12'hF12, 12'hF13: w_rdata = '0;
      12'hF14: w_rdata = HART_ID;
      12'h301: w_rdata = 32'h4000_0100;
      12'h300: w_rdata = {19'b0, 2'b11, 3'b0, r_mpie, 3'b0, r_mie, 3'b0};
      12'h304: w_rdata = {24'b0, r_mtie, 7'b0};
      12'h305: w_rdata = {r_mtvec, 2'b00};
      12'h340: w_rdata = r_mscratch;
      12'h341: w_rdata = r_mepc;
      12'h342: w_rdata = r_mcause;
      12'h343: w_rdata = r_mbadaddr;
      12'h344: w_rdata = {24'b0, r_mtip, 7'b0};
      12'hB00: w_rdata = r_cycle[31:0];
      12'hB02: w_rdata = r_instret[31:0];
      12'hB80: w_rdata = r_cycle[63:32];
      12'hB82: w_rdata = r_instret[63:32];
      12'h7C0: w_rdata = r_timecmp[31:0];
      12'h7C1: w_rdata = r_timecmp[63:32];
`endif
      default: w_known = 1'b0;
    endcase
  end

  // RS/RC with a zero mask are pure reads and never count as writes.
  assign w_wr_intent   = csr_req_i &&
                         (csr_op_i == 2'b01 || (csr_op_i != 2'b00 && csr_wdata_i != '0));
  assign w_ro          = (csr_addr_i[11:10] == 2'b11);
  assign csr_rdata_o   = w_rdata;
  assign csr_illegal_o = !w_known || (w_wr_intent && w_ro);

`ifdef KAMUS_MACHINE_MODE_EN
  // Write value for RW/RS/RC; trap and MRET take precedence over any CSR write.
  always_comb begin
    w_wval = csr_wdata_i;
    case (csr_op_i)
      2'b10:   w_wval = w_rdata | csr_wdata_i;
      2'b11:   w_wval = w_rdata & ~csr_wdata_i;
      default: w_wval = csr_wdata_i;
    endcase
  end
  assign w_we = w_wr_intent && w_known && !w_ro && !trap_i && !mret_i;
`endif

  // Free-running counters; a written half overrides the increment, the other half holds.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cycle   <= '0;
      r_instret <= '0;
    end else begin
      r_cycle   <= r_cycle + 64'd1;
      r_instret <= r_instret + {63'd0, instr_retire_i};
`ifdef KAMUS_MACHINE_MODE_EN
      if (w_we) begin
        case (csr_addr_i)
          12'hB00: r_cycle   <= {r_cycle[63:32], w_wval};
          12'hB80: r_cycle   <= {w_wval, r_cycle[31:0]};
          12'hB02: r_instret <= {r_instret[63:32], w_wval};
          12'hB82: r_instret <= {w_wval, r_instret[31:0]};
          default: ;
        endcase
      end
`endif
    end
  end

`ifdef KAMUS_MACHINE_MODE_EN
  // Machine state: trap entry, then MRET, then CSR writes; MTIP sampled every cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_timecmp  <= '1;
      r_mie      <= 1'b0;
      r_mpie     <= 1'b0;
      r_mtie     <= 1'b0;
      r_mtip     <= 1'b0;
      r_mtvec    <= MTVEC_RESET[31:2];
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
      r_mbadaddr <= '0;
    end else begin
      r_mtip <= (r_cycle >= r_timecmp);
      if (trap_i) begin
        r_mepc     <= trap_pc_i;
        r_mcause   <= trap_cause_i;
        r_mbadaddr <= trap_tval_i;
        r_mpie     <= r_mie;
        r_mie      <= 1'b0;
      end else if (mret_i) begin
        r_mie  <= r_mpie;
        r_mpie <= 1'b1;
      end else if (w_we) begin
        case (csr_addr_i)
          12'h300: begin
            r_mie  <= w_wval[3];
            r_mpie <= w_wval[7];
          end
          12'h304: r_mtie     <= w_wval[7];
          12'h305: r_mtvec    <= w_wval[31:2];
          12'h340: r_mscratch <= w_wval;
          12'h341: r_mepc     <= w_wval;
          12'h342: r_mcause   <= w_wval;
          12'h343: r_mbadaddr <= w_wval;
          12'h7C0: r_timecmp  <= {r_timecmp[63:32], w_wval};
          12'h7C1: r_timecmp  <= {w_wval, r_timecmp[31:0]};
          default: ;
        endcase
      end
    end
  end

  assign mtvec_o      = {r_mtvec, 2'b00};
  assign mepc_o       = {r_mepc[31:2], 2'b00};
  assign mie_global_o = r_mie;
  assign timer_irq_o  = r_mtip & r_mtie & r_mie;
`else
  // Trap inputs and parameters have no effect in the counter-only build.
  logic w_unused;
  assign w_unused = ^{trap_i, trap_cause_i, trap_pc_i, trap_tval_i, mret_i,
                      HART_ID, MTVEC_RESET};

  assign mtvec_o      = '0;
  assign mepc_o       = '0;
  assign mie_global_o = 1'b0;
  assign timer_irq_o  = 1'b0;
`endif

endmodule

// File: tb/tb_kamus_csr_file.sv
// Scoreboard bench for kamus_csr_file: a behavioural model predicts every CSR read and the
// status outputs; a negedge monitor pops and compares whenever a request is presented.
module tb_kamus_csr_file;

`ifdef KAMUS_MACHINE_MODE_EN
  localparam bit MM = 1'b1;
`else
  localparam bit MM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        csr_req;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        retire;
  logic        trap;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic [31:0] trap_tval;
  logic        mret;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic        mie_g;
  logic        irq;

  kamus_csr_file dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .csr_req_i      (csr_req),
    .csr_op_i       (csr_op),
    .csr_addr_i     (csr_addr),
    .csr_wdata_i    (csr_wdata),
    .csr_rdata_o    (csr_rdata),
    .csr_illegal_o  (csr_illegal),
    .instr_retire_i (retire),
    .trap_i         (trap),
    .trap_cause_i   (trap_cause),
    .trap_pc_i      (trap_pc),
    .trap_tval_i    (trap_tval),
    .mret_i         (mret),
    .mtvec_o        (mtvec),
    .mepc_o         (mepc),
    .mie_global_o   (mie_g),
    .timer_irq_o    (irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        ill;
    logic        irq;
    logic        gie;
    logic [31:0] mtvec;
    logic [31:0] mepc;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  // Reference model state
  logic [63:0] m_cycle, m_instret, m_timecmp;
  bit          m_mtip, m_mie, m_mpie, m_mtie;
  logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mbad;

  function automatic void model_reset();
    m_cycle = 0; m_instret = 0; m_timecmp = 64'hFFFF_FFFF_FFFF_FFFF;
    m_mtip = 0; m_mie = 0; m_mpie = 0; m_mtie = 0;
    m_mtvec = 32'h0000_0100; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mbad = 0;
  endfunction

  function automatic void model_read(input logic [11:0] a, output logic [31:0] d,
                                     output bit known);
    bit user;
    user  = (a == 12'hC00 || a == 12'hC01 || a == 12'hC02 ||
             a == 12'hC80 || a == 12'hC81 || a == 12'hC82);
    d     = 0;
    known = 1;
    if (!user && !MM) begin
      known = 0;
      return;
    end
    case (a)
      12'hC00, 12'hC01, 12'hB00: d = m_cycle[31:0];
      12'hC80, 12'hC81, 12'hB80: d = m_cycle[63:32];
      12'hC02, 12'hB02:          d = m_instret[31:0];
      12'hC82, 12'hB82:          d = m_instret[63:32];
      12'hF11, 12'hF12, 12'hF13, 12'hF14: d = 0;
      12'h301: d = 32'h4000_0100;
      12'h300: d = 32'h1800 + (m_mpie ? 32'h80 : 0) + (m_mie ? 32'h8 : 0);
      12'h304: d = m_mtie ? 32'h80 : 0;
      12'h305: d = m_mtvec;
      12'h340: d = m_mscratch;
      12'h341: d = m_mepc;
      12'h342: d = m_mcause;
      12'h343: d = m_mbad;
      12'h344: d = m_mtip ? 32'h80 : 0;
      12'h7C0: d = m_timecmp[31:0];
      12'h7C1: d = m_timecmp[63:32];
      default: known = 0;
    endcase
  endfunction

  function automatic bit wants_write();
    return csr_req && (csr_op == 2'b01 || (csr_op != 2'b00 && csr_wdata != 0));
  endfunction

  // Advance the model across one clock edge using the inputs currently applied.
  function automatic void model_step();
    logic [31:0] old, nv;
    logic [63:0] c_n, i_n;
    bit          known, mtip_n;
    model_read(csr_addr, old, known);
    c_n = m_cycle + 64'd1;
    i_n = m_instret + (retire ? 64'd1 : 64'd0);
    if (MM) begin
      mtip_n = (m_cycle >= m_timecmp);
      if (trap) begin
        m_mepc = trap_pc; m_mcause = trap_cause; m_mbad = trap_tval;
        m_mpie = m_mie; m_mie = 0;
      end else if (mret) begin
        m_mie = m_mpie; m_mpie = 1;
      end else if (wants_write() && known && csr_addr[11:10] != 2'b11) begin
        if (csr_op == 2'b01)      nv = csr_wdata;
        else if (csr_op == 2'b10) nv = old | csr_wdata;
        else                      nv = old & ~csr_wdata;
        case (csr_addr)
          12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
          12'h304: m_mtie = nv[7];
          12'h305: m_mtvec = nv & 32'hFFFF_FFFC;
          12'h340: m_mscratch = nv;
          12'h341: m_mepc = nv;
          12'h342: m_mcause = nv;
          12'h343: m_mbad = nv;
          12'hB00: c_n[31:0] = nv;
          12'hB80: begin c_n[63:32] = nv; c_n[31:0] = m_cycle[31:0]; end
          12'hB02: begin i_n[31:0] = nv; i_n[63:32] = m_instret[63:32]; end
          12'hB82: begin i_n[63:32] = nv; i_n[31:0] = m_instret[31:0]; end
          12'h7C0: m_timecmp[31:0] = nv;
          12'h7C1: m_timecmp[63:32] = nv;
          default: ;
        endcase
        if (csr_addr == 12'hB00) c_n[63:32] = m_cycle[63:32];
      end
      m_mtip = mtip_n;
    end
    m_cycle   = c_n;
    m_instret = i_n;
  endfunction

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endfunction

  // Push the expected response (if a request is presented), step the model, cross one edge.
  task automatic tick(input string tag);
    exp_t        e;
    logic [31:0] d;
    bit          known;
    if (csr_req) begin
      model_read(csr_addr, d, known);
      e.rdata = d;
      e.ill   = !known || (wants_write() && csr_addr[11:10] == 2'b11);
      e.irq   = MM && m_mtip && m_mtie && m_mie;
      e.gie   = MM && m_mie;
      e.mtvec = MM ? m_mtvec : 0;
      e.mepc  = MM ? (m_mepc & 32'hFFFF_FFFC) : 0;
      exp_q.push_back(e);
      tag_q.push_back(tag);
    end
    if (rst_n) model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    csr_req = 0; csr_op = 0; csr_addr = 0; csr_wdata = 0; retire = 0;
    trap = 0; trap_cause = 0; trap_pc = 0; trap_tval = 0; mret = 0;
  endtask

  task automatic op(input logic [1:0] o, input logic [11:0] a, input logic [31:0] d,
                    input string tag);
    csr_req = 1; csr_op = o; csr_addr = a; csr_wdata = d;
    tick(tag);
    csr_req = 0; csr_op = 0; csr_wdata = 0;
  endtask

  task automatic rd(input logic [11:0] a, input string tag);
    op(2'b10, a, 32'h0, tag);
  endtask

  // Monitor: compare whenever the DUT is presented with a request.
  exp_t  mon_e;
  string mon_t;
  always @(negedge clk) begin
    if (csr_req === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_underflow: got empty queue, expected an entry");
      end else begin
        mon_e = exp_q.pop_front();
        mon_t = tag_q.pop_front();
        check({mon_t, ".rdata"},   csr_rdata, mon_e.rdata);
        check({mon_t, ".illegal"}, {31'b0, csr_illegal}, {31'b0, mon_e.ill});
        check({mon_t, ".irq"},     {31'b0, irq}, {31'b0, mon_e.irq});
        check({mon_t, ".mie_g"},   {31'b0, mie_g}, {31'b0, mon_e.gie});
        check({mon_t, ".mtvec"},   mtvec, mon_e.mtvec);
        check({mon_t, ".mepc"},    mepc, mon_e.mepc);
      end
    end
  end

  logic [11:0] addr_list [30] = '{
    12'hC00, 12'hC01, 12'hC02, 12'hC80, 12'hC81, 12'hC82, 12'hF11, 12'hF12, 12'hF13, 12'hF14,
    12'h301, 12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344, 12'hB00,
    12'hB02, 12'hB80, 12'hB82, 12'h7C0, 12'h7C1, 12'h123, 12'hC03, 12'h7C2, 12'hB01, 12'h000
  };

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    rd(12'hC00, "reset_cycle");
    rd(12'h305, "reset_mtvec");
    rst_n = 1;

    // Reset and cycle count
    repeat (10) tick("idle");
    rd(12'hC00, "cycle_after_10");
    rd(12'hC80, "cycleh");
    op(2'b01, 12'hC00, 32'h5, "write_ro_cycle");
    op(2'b10, 12'hC00, 32'h0, "rs0_cycle");
    rd(12'h300, "mstatus_read");

    // Set/clear ops
    op(2'b01, 12'h340, 32'hA5A5_0000, "rw_mscratch");
    op(2'b10, 12'h340, 32'h0000_00FF, "rs_mscratch");
    rd(12'h340, "mscratch_after_rs");
    op(2'b11, 12'h340, 32'hA500_0000, "rc_mscratch");
    rd(12'h340, "mscratch_after_rc");
    op(2'b01, 12'h301, 32'h1234_5678, "misa_write");
    rd(12'h301, "misa_read");
    rd(12'hF14, "mhartid");

    // Counter wrap and write priority
    op(2'b01, 12'hB00, 32'hFFFF_FFFF, "wr_mcycle");
    op(2'b01, 12'hB80, 32'hFFFF_FFFF, "wr_mcycleh");
    rd(12'hC00, "cycle_all_ones");
    rd(12'hC80, "cycleh_wrapped");
    retire = 1;
    op(2'b01, 12'hB02, 32'h0000_1234, "wr_minstret_retire");
    retire = 0;
    rd(12'hC02, "instret_held");

    // Timer
    op(2'b01, 12'hB80, 32'h0, "clr_mcycleh");
    op(2'b01, 12'hB00, 32'h0, "clr_mcycle");
    op(2'b01, 12'h7C1, 32'h0, "wr_mtimecmph");
    op(2'b01, 12'h7C0, 32'd20, "wr_mtimecmp");
    op(2'b01, 12'h304, 32'h80, "wr_mie");
    op(2'b01, 12'h300, 32'h8, "wr_mstatus");
    for (int i = 0; i < 22; i++) rd(12'h344, "timer_wait");
    op(2'b01, 12'h7C1, 32'h1, "raise_mtimecmph");
    for (int i = 0; i < 3; i++) rd(12'h344, "timer_drop");

    // Trap and MRET
    op(2'b01, 12'h340, 32'h1111, "mscratch_pre_trap");
    trap = 1; trap_pc = 32'h104; trap_cause = 32'h8000_0007; trap_tval = 32'hBAD;
    op(2'b01, 12'h340, 32'hDEAD, "trap_with_write");
    trap = 0;
    rd(12'h341, "mepc_after_trap");
    rd(12'h300, "mstatus_after_trap");
    rd(12'h342, "mcause_after_trap");
    rd(12'h340, "mscratch_dropped");
    mret = 1;
    tick("mret");
    mret = 0;
    rd(12'h300, "mstatus_after_mret");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      csr_req    = ($urandom_range(0, 9) < 7);
      csr_op     = 2'($urandom_range(0, 3));
      csr_addr   = addr_list[$urandom_range(0, 29)];
      csr_wdata  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      retire     = $urandom_range(0, 1) == 1;
      trap       = ($urandom_range(0, 31) == 0);
      mret       = ($urandom_range(0, 19) == 0);
      trap_pc    = $urandom;
      trap_cause = $urandom;
      trap_tval  = $urandom;
      tick("random");
    end
    idle_inputs();

    // Reset in the middle of a write
    csr_req = 1; csr_op = 2'b01; csr_addr = 12'h340; csr_wdata = 32'h55;
    #2;
    rst_n = 0;
    idle_inputs();
    model_reset();
    @(posedge clk);
    #1;
    rd(12'h305, "mtvec_in_reset");
    rst_n = 1;
    rd(12'h340, "mscratch_after_reset");
    rd(12'hC00, "cycle_after_reset");

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
